// File: rtl/soft_core_cpu_display_scan_if.sv
// soft_core_cpu_display_scan_if: display enable, capture bytes and 7-segment pins
interface soft_core_cpu_display_scan_if;
  logic       DISP_EN;
  logic [7:0] NUM_BUFF1;
  logic [7:0] NUM_BUFF0;
  logic [6:0] SEG;
  logic [3:0] DIG_SEL;
  logic       FRAME_TICK;
  modport master (output DISP_EN, NUM_BUFF1, NUM_BUFF0, input SEG, DIG_SEL, FRAME_TICK);
  modport slave (input DISP_EN, NUM_BUFF1, NUM_BUFF0, output SEG, DIG_SEL, FRAME_TICK);
endinterface

// File: rtl/soft_core_cpu_display_scan.sv
// soft_core_cpu_display_scan: 4-digit blank/drive scanner with frame-coherent snapshot of both bytes.
// Define DISPLAY_LEADING_ZERO_BLANK_EN to blank zero upper nibbles on digits 3 and 1.
module soft_core_cpu_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8,
  parameter int DIV_WIDTH    = 16
) (
  input logic CLK,
  input logic CLR,
  soft_core_cpu_display_scan_if.slave bus
);
  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] DRIVE_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [15:0]          snap_q, snap_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [3:0]           nibble;
  logic [6:0]           hex;
  logic                 lz_blank;
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + 1'b1;
    snap_d       = snap_q;
    frame_tick_d = 1'b0;
    if (!bus.DISP_EN) begin
      state_d = S_OFF;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else if (state_q == S_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = S_DRIVE;
        cnt_d   = '0;
      end
    end else if (state_q == S_DRIVE) begin
      if (cnt_q == DRIVE_LAST) begin
        state_d = S_BLANK;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
        // a completed frame re-latches both bytes together
        if (idx_q == 2'd3) begin
          snap_d       = {bus.NUM_BUFF1, bus.NUM_BUFF0};
          frame_tick_d = 1'b1;
        end
      end
    end else begin
      state_d      = S_BLANK;
      idx_d        = 2'd0;
      cnt_d        = '0;
      snap_d       = {bus.NUM_BUFF1, bus.NUM_BUFF0};
      frame_tick_d = 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q      <= S_OFF;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      snap_q       <= 16'h0000;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      frame_tick_q <= frame_tick_d;
    end
  end
  always_comb begin
    nibble = snap_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  assign lz_blank = (idx_q == 2'd3 && snap_q[15:12] == 4'h0) || (idx_q == 2'd1 && snap_q[7:4] == 4'h0);
`else
  assign lz_blank = 1'b0;
`endif
  assign bus.SEG        = (state_q == S_DRIVE && !lz_blank) ? hex : 7'h7F;
  assign bus.DIG_SEL    = (state_q == S_DRIVE) ? ~(4'b0001 << idx_q) : 4'hF;
  assign bus.FRAME_TICK = frame_tick_q;
endmodule
